// File: rtl/fifo_tx_apb_ser_if.sv
// APB slave bus bundle for the Zigbee TX FIFO.
// The master modport drives select/enable/address/data; the slave modport returns read data and the response.
interface fifo_tx_apb_ser_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/fifo_tx_apb_ser.sv
// Zigbee TX FIFO: APB-written words are queued and serialized one bit per en_IQ strobe.
// It also provides a STATUS register, sticky overflow/underflow flags, almost-full and flush.
module fifo_tx_apb_ser #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 56,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  fifo_tx_apb_ser_if.slave        apb,
  input  logic                    en_IQ,
  output logic                    data_out,
  output logic                    IQ_rate,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [3:0]    ADDR_TXDATA = 4'h0;
  localparam logic [3:0]    ADDR_STATUS = 4'h4;
  localparam logic [3:0]    ADDR_CTRL   = 4'h8;
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF      = LW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     level_r, level_nxt_s;
  logic              empty_r, full_r, af_r, ovf_r, unf_r;
  logic [31:0]       prdata_r, rdata_s, status_s;
  logic              pslverr_r, pslverr_nxt_s;
  ser_state_t        state_r, state_nxt_s;
  logic [DATA_W-1:0] shreg_r, shreg_nxt_s, head_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic              dout_r, dout_nxt_s, iq_r, iq_nxt_s;
  logic              setup_s, access_s, wr_txdata_s, push_s, ovf_evt_s;
  logic              flush_s, clr_s, pop_s, unf_evt_s, addr_ok_s;
  logic              unused_s;

  assign unused_s = ^apb.pwdata;
  assign head_s   = mem_r[rd_ptr_r];

  // APB decode; the response is computed in the setup phase so it is registered in time for the access phase
  always_comb begin
    setup_s     = apb.psel & ~apb.penable;
    access_s    = apb.psel & apb.penable;
    wr_txdata_s = access_s & apb.pwrite & (apb.paddr == ADDR_TXDATA);
    // pslverr_r still holds the setup-phase full decision, so a concurrent pop cannot rescue the write
    push_s      = wr_txdata_s & ~pslverr_r;
    ovf_evt_s   = wr_txdata_s & pslverr_r;
    clr_s       = access_s & apb.pwrite & (apb.paddr == ADDR_CTRL) & apb.pwdata[0];
    flush_s     = access_s & apb.pwrite & (apb.paddr == ADDR_CTRL) & apb.pwdata[1];
    addr_ok_s   = (apb.paddr == ADDR_TXDATA) | (apb.paddr == ADDR_STATUS) | (apb.paddr == ADDR_CTRL);
    status_s            = 32'd0;
    status_s[0]         = empty_r;
    status_s[1]         = full_r;
    status_s[2]         = af_r;
    status_s[3]         = ovf_r;
    status_s[4]         = unf_r;
    status_s[16 +: LW]  = level_r;
    if (~apb.pwrite && (apb.paddr == ADDR_STATUS)) begin
      rdata_s = status_s;
    end else begin
      rdata_s = 32'd0;
    end
    pslverr_nxt_s = ~addr_ok_s | (apb.pwrite & (apb.paddr == ADDR_TXDATA) & full_r);
  end

  // APB response registers, valid only during the access phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prdata_r  <= 32'd0;
      pslverr_r <= 1'b0;
    end else if (setup_s) begin
      prdata_r  <= rdata_s;
      pslverr_r <= pslverr_nxt_s;
    end else begin
      prdata_r  <= 32'd0;
      pslverr_r <= 1'b0;
    end
  end

  // Serializer next-state: pop on IDLE, shift out remaining bits in SHIFT; flush aborts
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    dout_nxt_s  = dout_r;
    iq_nxt_s    = 1'b0;
    pop_s       = 1'b0;
    unf_evt_s   = 1'b0;
    if (flush_s) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end else if (en_IQ) begin
      case (state_r)
        IDLE: begin
          if (!empty_r) begin
            pop_s       = 1'b1;
            iq_nxt_s    = 1'b1;
            cnt_nxt_s   = CW'(1);
            state_nxt_s = SHIFT;
            if (MSB_FIRST) begin
              dout_nxt_s  = head_s[DATA_W-1];
              shreg_nxt_s = {head_s[DATA_W-2:0], 1'b0};
            end else begin
              dout_nxt_s  = head_s[0];
              shreg_nxt_s = {1'b0, head_s[DATA_W-1:1]};
            end
          end else begin
            unf_evt_s = 1'b1;
          end
        end
        SHIFT: begin
          iq_nxt_s  = 1'b1;
          cnt_nxt_s = cnt_r + CW'(1);
          if (MSB_FIRST) begin
            dout_nxt_s  = shreg_r[DATA_W-1];
            shreg_nxt_s = {shreg_r[DATA_W-2:0], 1'b0};
          end else begin
            dout_nxt_s  = shreg_r[0];
            shreg_nxt_s = {1'b0, shreg_r[DATA_W-1:1]};
          end
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end else begin
      iq_nxt_s = 1'b0;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      shreg_r <= '0;
      cnt_r   <= '0;
      dout_r  <= 1'b0;
      iq_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dout_r  <= dout_nxt_s;
      iq_r    <= iq_nxt_s;
    end
  end

  // Occupancy update; flush wins over a same-cycle pop
  always_comb begin
    if (flush_s) begin
      level_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + LW'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LW'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Pointers, occupancy and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      empty_r <= (level_nxt_s == '0);
      full_r  <= (level_nxt_s == LVL_FULL);
      af_r    <= (level_nxt_s >= LVL_AF);
    end
  end

  // Sticky error flags; a new event in the clearing cycle survives the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= (ovf_r & ~clr_s) | ovf_evt_s;
      unf_r <= (unf_r & ~clr_s) | unf_evt_s;
    end
  end

  // Word storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= apb.pwdata[DATA_W-1:0];
  end

  assign apb.prdata  = prdata_r;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = pslverr_r;
  assign data_out    = dout_r;
  assign IQ_rate     = iq_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = af_r;
  assign level       = level_r;
endmodule

// File: tb/tb_fifo_tx_apb_ser.sv
// Bench for fifo_tx_apb_ser: an LSB-first and an MSB-first instance share one stimulus stream
// and are compared every cycle against a queue-based model of the FIFO and bit stream.
module tb_fifo_tx_apb_ser;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AF    = 56;
  localparam int LW    = 7;

  logic clk = 1'b0;
  logic reset;
  logic psel, penable, pwrite, en_iq;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic d0, d1, iq0, iq1, empty0, empty1, full0, full1, af0, af1;
  logic [LW-1:0] lvl0, lvl1;

  fifo_tx_apb_ser_if apb0();
  fifo_tx_apb_ser_if apb1();
  assign apb0.psel = psel;  assign apb0.penable = penable;  assign apb0.pwrite = pwrite;
  assign apb0.paddr = paddr; assign apb0.pwdata = pwdata;
  assign apb1.psel = psel;  assign apb1.penable = penable;  assign apb1.pwrite = pwrite;
  assign apb1.paddr = paddr; assign apb1.pwdata = pwdata;

  always #10 clk = ~clk;

  fifo_tx_apb_ser #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .apb(apb0), .en_IQ(en_iq), .data_out(d0), .IQ_rate(iq0),
    .empty(empty0), .full(full0), .almost_full(af0), .level(lvl0));
  fifo_tx_apb_ser #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .apb(apb1), .en_IQ(en_iq), .data_out(d1), .IQ_rate(iq1),
    .empty(empty1), .full(full1), .almost_full(af1), .level(lvl1));

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [7:0]  cur;
  int          left;
  logic        m_ovf, m_unf, m_rej;
  logic        e_iq, e_d0, e_d1, e_err;
  logic [31:0] e_rd;

  // stimulus / capture state
  int          en_mode = 0;
  int          cyc = 0;
  logic [7:0]  cap0, cap1;
  int          capn = 0;
  logic [7:0]  bytes0[$];
  logic [7:0]  bytes1[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (q.size() == 0);
    s[1] = (q.size() == DEPTH);
    s[2] = (q.size() >= AF);
    s[3] = m_ovf;
    s[4] = m_unf;
    s[31:16] = 16'(q.size());
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = 8'd0; left = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_rej = 1'b0;
    e_iq = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0; e_err = 1'b0; e_rd = 32'd0;
  endtask

  // one clock edge of the reference: APB response, serializer, push, sticky flags
  task automatic model_step();
    logic acc, setup, flush, clr, do_push, ovf_evt, unf_evt;
    int k;
    acc     = psel && penable;
    setup   = psel && !penable;
    flush   = acc && pwrite && (paddr == 4'h8) && pwdata[1];
    clr     = acc && pwrite && (paddr == 4'h8) && pwdata[0];
    do_push = acc && pwrite && (paddr == 4'h0) && !m_rej;
    ovf_evt = acc && pwrite && (paddr == 4'h0) && m_rej;
    unf_evt = 1'b0;
    if (setup) begin
      m_rej = pwrite && (paddr == 4'h0) && (q.size() == DEPTH);
      e_err = !(paddr == 4'h0 || paddr == 4'h4 || paddr == 4'h8) || m_rej;
      e_rd  = (!pwrite && paddr == 4'h4) ? status_word() : 32'd0;
    end else begin
      e_err = 1'b0;
      e_rd  = 32'd0;
    end
    if (flush) begin
      q.delete();
      left = 0;
      e_iq = 1'b0;
    end else if (en_iq) begin
      k = -1;
      if (left > 0) begin
        k = DW - left;
        left--;
      end else if (q.size() > 0) begin
        cur  = q.pop_front();
        k    = 0;
        left = DW - 1;
      end else begin
        unf_evt = 1'b1;
      end
      if (k >= 0) begin
        e_iq = 1'b1;
        e_d0 = cur[k];
        e_d1 = cur[DW-1-k];
      end else begin
        e_iq = 1'b0;
      end
    end else begin
      e_iq = 1'b0;
    end
    if (do_push) q.push_back(pwdata[7:0]);
    m_ovf = (m_ovf && !clr) || ovf_evt;
    m_unf = (m_unf && !clr) || unf_evt;
  endtask

  task automatic compare_outputs();
    check_val("iq_lsb",     iq0, e_iq);
    check_val("iq_msb",     iq1, e_iq);
    check_val("dout_lsb",   d0, e_d0);
    check_val("dout_msb",   d1, e_d1);
    check_val("level_lsb",  lvl0, q.size());
    check_val("level_msb",  lvl1, q.size());
    check_val("empty",      empty0, q.size() == 0);
    check_val("full",       full0, q.size() == DEPTH);
    check_val("almost_full", af0, q.size() >= AF);
    check_val("prdata",     apb0.prdata, e_rd);
    check_val("pslverr",    apb0.pslverr, e_err);
    check_val("pslverr_msb", apb1.pslverr, e_err);
  endtask

  // one clock: drive en_IQ, step the model at the edge, compare on the falling edge
  task automatic cycle();
    case (en_mode)
      0:       en_iq = 1'b0;
      1:       en_iq = 1'b1;
      2:       en_iq = (cyc % 4 == 0);
      3:       en_iq = ($urandom_range(0, 2) != 0);
      default: en_iq = 1'b0;
    endcase
    cyc++;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_outputs();
    if (iq0 === 1'b1) begin
      cap0 = {d0, cap0[7:1]};
      cap1 = {cap1[6:0], d1};
      capn++;
      if (capn == 8) begin
        bytes0.push_back(cap0);
        bytes1.push_back(cap1);
        capn = 0;
      end
    end
  endtask

  task automatic clear_capture();
    capn = 0;
    bytes0.delete();
    bytes1.delete();
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cycle();
    penable = 1'b1;
    rd  = apb0.prdata;
    err = apb0.pslverr;
    cycle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'd0;
    en_mode = 0; en_iq = 1'b0;
    #1;
    model_reset();
    check_val("rst_iq",     iq0, 1'b0);
    check_val("rst_dout",   d0, 1'b0);
    check_val("rst_level",  lvl0, 7'd0);
    check_val("rst_empty",  empty0, 1'b1);
    check_val("rst_full",   full0, 1'b0);
    check_val("rst_af",     af0, 1'b0);
    check_val("rst_pslverr", apb0.pslverr, 1'b0);
    check_val("rst_prdata", apb0.prdata, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    clear_capture();
  endtask

  logic [31:0] rd;
  logic        err;
  int          pulses;

  initial begin
    reset = 1'b1;
    do_reset();
    check_val("pready", apb0.pready, 1'b1);

    // fill to full with 0..63
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(1'b1, 4'h0, i, rd, err);
      check_val("push_err", err, 1'b0);
    end
    apb_xfer(1'b0, 4'h4, 32'd0, rd, err);
    check_val("status_full", rd, 32'h0040_0006);

    // overflow, then sticky clear
    apb_xfer(1'b1, 4'h0, 32'h0000_00EE, rd, err);
    check_val("ovf_err", err, 1'b1);
    check_val("ovf_level", lvl0, 7'd64);
    apb_xfer(1'b0, 4'h4, 32'd0, rd, err);
    check_val("ovf_sticky", rd, 32'h0040_000E);
    apb_xfer(1'b1, 4'h8, 32'h1, rd, err);
    apb_xfer(1'b0, 4'h4, 32'd0, rd, err);
    check_val("ovf_cleared", rd, 32'h0040_0006);

    // continuous drain
    clear_capture();
    en_mode = 1;
    pulses = 0;
    for (int i = 0; i < 512; i++) begin
      cycle();
      if (iq0 === 1'b1) pulses++;
    end
    check_val("drain_pulses", pulses, 512);
    check_val("drain_empty", empty0, 1'b1);
    check_val("drain_bytes", bytes0.size(), 64);
    for (int i = 0; i < bytes0.size(); i++) check_val("drain_byte", bytes0[i], i);
    cycle();
    en_mode = 0;
    apb_xfer(1'b0, 4'h4, 32'd0, rd, err);
    check_val("unf_sticky", rd[4], 1'b1);
    apb_xfer(1'b1, 4'h8, 32'h1, rd, err);

    // sparse en_IQ
    clear_capture();
    apb_xfer(1'b1, 4'h0, 32'h5A, rd, err);
    en_mode = 2;
    for (int i = 0; i < 40; i++) cycle();
    check_val("sparse_lsb", bytes0.size() > 0 ? bytes0[0] : 8'hxx, 8'h5A);
    check_val("sparse_msb", bytes1.size() > 0 ? bytes1[0] : 8'hxx, 8'h5A);

    // MSB-first order and bad address
    en_mode = 0;
    clear_capture();
    apb_xfer(1'b1, 4'h0, 32'hA5, rd, err);
    en_mode = 1;
    for (int i = 0; i < 12; i++) cycle();
    en_mode = 0;
    check_val("order_msb", bytes1.size() > 0 ? bytes1[0] : 8'hxx, 8'hA5);
    check_val("order_lsb", bytes0.size() > 0 ? bytes0[0] : 8'hxx, 8'hA5);
    apb_xfer(1'b0, 4'hC, 32'd0, rd, err);
    check_val("bad_addr", err, 1'b1);

    // flush during the third bit, then recovery
    for (int i = 0; i < 10; i++) apb_xfer(1'b1, 4'h0, $urandom, rd, err);
    en_mode = 1;
    cycle();
    cycle();
    apb_xfer(1'b1, 4'h8, 32'h2, rd, err);
    check_val("flush_iq", iq0, 1'b0);
    check_val("flush_level", lvl0, 7'd0);
    check_val("flush_empty", empty0, 1'b1);
    clear_capture();
    apb_xfer(1'b1, 4'h0, 32'h3C, rd, err);
    for (int i = 0; i < 10; i++) cycle();
    check_val("flush_recover", bytes0.size() > 0 ? bytes0[0] : 8'hxx, 8'h3C);

    // same recovery via reset mid-word
    en_mode = 0;
    for (int i = 0; i < 10; i++) apb_xfer(1'b1, 4'h0, $urandom, rd, err);
    en_mode = 1;
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    en_mode = 1;
    apb_xfer(1'b1, 4'h0, 32'h3C, rd, err);
    for (int i = 0; i < 10; i++) cycle();
    check_val("reset_recover", bytes0.size() > 0 ? bytes0[0] : 8'hxx, 8'h3C);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r;
      logic [3:0] a;
      if (n % 100 == 0) en_mode = (n % 200 == 0) ? 0 : 3;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        apb_xfer(1'b1, 4'h0, $urandom, rd, err);
      end else if (r < 72) begin
        apb_xfer(1'b0, 4'h4, 32'd0, rd, err);
      end else if (r < 77) begin
        apb_xfer(1'b1, 4'h4, $urandom, rd, err);
      end else if (r < 82) begin
        apb_xfer(1'b0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'h8, 32'd0, rd, err);
      end else if (r < 90) begin
        apb_xfer(1'b1, 4'h8, {$urandom_range(0, 7) << 2, ($urandom_range(0, 4) == 0), 1'(($urandom_range(0, 1)))}, rd, err);
      end else begin
        a = 4'($urandom_range(0, 15));
        if (a == 4'h0 || a == 4'h4 || a == 4'h8) a = a + 4'h1;
        apb_xfer(1'($urandom_range(0, 1)), a, $urandom, rd, err);
      end
      for (int j = $urandom_range(0, 2); j > 0; j--) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
